// File: rtl/prach_cic_decim_pkg.sv
// Shared constants and helpers for the PRACH CIC decimator.
package prach_pkg;

  localparam int SMP_W       = 16;  // complex sample component width
  localparam int CHN_W       = 8;   // TDM channel index width
  localparam int DEF_NUM_ANT = 3;
  localparam int DEF_NUM_CHN = 8;
  localparam int DEF_DECIM   = 4;

  // log2 of a power-of-two decimation ratio
  function automatic int log2_decim(input int d);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < d) r = i + 1;
    return r;
  endfunction

  // Bits needed to index NUM_CHN channel slots (at least 1)
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prach_cic_decim_if.sv
// TDM stream bundle between the PRACH mixer, the CIC decimator and the next stage.
interface prach_cic_decim_if
  import prach_pkg::*;
#(
  parameter int NUM_ANT = DEF_NUM_ANT
);
  logic [NUM_ANT-1:0][SMP_W-1:0] din_dr;
  logic [NUM_ANT-1:0][SMP_W-1:0] din_di;
  logic [CHN_W-1:0]              din_chn;
  logic                          sync_in;
  logic [NUM_ANT-1:0][SMP_W-1:0] dout_dr;
  logic [NUM_ANT-1:0][SMP_W-1:0] dout_di;
  logic [CHN_W-1:0]              dout_chn;
  logic                          dout_valid;
  logic                          sync_out;

  // Stream source / result sink side
  modport master (
    output din_dr, din_di, din_chn, sync_in,
    input  dout_dr, dout_di, dout_chn, dout_valid, sync_out
  );

  // Decimator side
  modport slave (
    input  din_dr, din_di, din_chn, sync_in,
    output dout_dr, dout_di, dout_chn, dout_valid, sync_out
  );
endinterface

// File: rtl/prach_cic_decim_ch.sv
// One antenna's I/Q CIC state: per-channel integrators (stage 2),
// per-channel comb delays (stage 3) and round-half-up scaling (stage 4).
module prach_cic_decim_ch
  import prach_pkg::*;
#(
  parameter int NUM_CHN = DEF_NUM_CHN,
  parameter int DECIM   = DEF_DECIM
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SMP_W-1:0]            i_x_re,
  input  logic [SMP_W-1:0]            i_x_im,
  input  logic [idx_w(NUM_CHN)-1:0]   i_idx_s1,
  input  logic [idx_w(NUM_CHN)-1:0]   i_idx_s2,
  input  logic                        i_dec_s2,
  output logic [SMP_W-1:0]            o_y_re,
  output logic [SMP_W-1:0]            o_y_im
);

  localparam int S = 2 * log2_decim(DECIM);
  localparam int W = SMP_W + S;
  localparam logic [W-1:0] RND = W'(1) << (S - 1);

  // index 0 = I path, 1 = Q path
  logic [W-1:0] r_i1  [2][NUM_CHN];
  logic [W-1:0] r_i2  [2][NUM_CHN];
  logic [W-1:0] r_i2d [2][NUM_CHN];
  logic [W-1:0] r_c1d [2][NUM_CHN];

  logic [1:0][SMP_W-1:0] w_x;
  logic [1:0][W-1:0]     w_i1n, w_i2n, w_c1, w_c2, w_rnd;
  logic [1:0][W-1:0]     r_s2_i2, r_s3_c2;
  logic [1:0][SMP_W-1:0] r_y;

  assign w_x    = {i_x_im, i_x_re};
  assign o_y_re = r_y[0];
  assign o_y_im = r_y[1];

  // Integrator sums, comb differences and rounding; all wrap modulo 2^W
  always_comb begin
    w_i1n = '0;
    w_i2n = '0;
    w_c1  = '0;
    w_c2  = '0;
    w_rnd = '0;
    for (int p = 0; p < 2; p++) begin
      w_i1n[p] = r_i1[p][i_idx_s1] + {{S{w_x[p][SMP_W-1]}}, w_x[p]};
      w_i2n[p] = r_i2[p][i_idx_s1] + w_i1n[p];
      w_c1[p]  = r_s2_i2[p] - r_i2d[p][i_idx_s2];
      w_c2[p]  = w_c1[p] - r_c1d[p][i_idx_s2];
      w_rnd[p] = r_s3_c2[p] + RND;
    end
  end

  // Stage 2: integrate every arrival of the channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++)
        for (int c = 0; c < NUM_CHN; c++) begin
          r_i1[p][c] <= '0;
          r_i2[p][c] <= '0;
        end
      r_s2_i2 <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_i1[p][i_idx_s1] <= w_i1n[p];
        r_i2[p][i_idx_s1] <= w_i2n[p];
        r_s2_i2[p]        <= w_i2n[p];
      end
    end
  end

  // Stage 3: comb section; delay lines advance only at decimation points
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++)
        for (int c = 0; c < NUM_CHN; c++) begin
          r_i2d[p][c] <= '0;
          r_c1d[p][c] <= '0;
        end
      r_s3_c2 <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_s3_c2[p] <= w_c2[p];
        if (i_dec_s2) begin
          r_i2d[p][i_idx_s2] <= r_s2_i2[p];
          r_c1d[p][i_idx_s2] <= w_c1[p];
        end
      end
    end
  end

  // Stage 4: divide by DECIM^2 (round half up); result always fits 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        r_y[p] <= SMP_W'(w_rnd[p] >> S);
    end
  end

endmodule

// File: rtl/prach_cic_decim.sv
// PRACH CIC decimator top: per-channel phase tracking, sync re-alignment,
// control pipeline and output registers around NUM_ANT CIC lanes.
// Optional macro PRACH_CIC_CHK_EN adds the err_seq sequence checker port.
module prach_cic_decim
  import prach_pkg::*;
#(
  parameter int NUM_ANT = DEF_NUM_ANT,
  parameter int NUM_CHN = DEF_NUM_CHN,
  parameter int DECIM   = DEF_DECIM
) (
  input  logic clk,
  input  logic rst_n,
  prach_cic_decim_if.slave bus
`ifdef PRACH_CIC_CHK_EN
  ,
  output logic err_seq
`endif
);

  localparam int PW     = log2_decim(DECIM);
  localparam int CW     = idx_w(NUM_CHN);
  localparam int STAGES = 4;

  logic [PW-1:0]      r_phase [NUM_CHN];
  logic [NUM_CHN-1:0] r_pend;
  logic               r_ch0_sw;   // channel 0's current window began at a sync

  logic [CW-1:0]      w_idx;
  logic               w_pend_eff, w_dec, w_is_ch0, w_sync_tag;
  logic [PW-1:0]      w_ph;
  logic [NUM_CHN-1:0] w_pend_nxt;

  logic [NUM_ANT-1:0][SMP_W-1:0] r_x_re, r_x_im, w_y_re, w_y_im;
  logic [STAGES:1]               r_vld_pipe, r_sync_pipe;
  logic [STAGES:1][CHN_W-1:0]    r_chn_pipe;

  // Effective phase of the arriving sample; a pending sync forces phase 0
  always_comb begin
    w_idx       = bus.din_chn[CW-1:0];
    w_pend_eff  = bus.sync_in | r_pend[w_idx];
    w_ph        = w_pend_eff ? '0 : r_phase[w_idx];
    w_dec       = (w_ph == PW'(DECIM - 1));
    w_is_ch0    = (bus.din_chn == '0);
    w_sync_tag  = w_dec & w_is_ch0 & r_ch0_sw;
    w_pend_nxt  = bus.sync_in ? '1 : r_pend;
    w_pend_nxt[w_idx] = 1'b0;
  end

  // Phase counters, sync-pending mask and channel-0 sync window flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHN; c++) r_phase[c] <= '0;
      r_pend   <= '0;
      r_ch0_sw <= 1'b0;
    end else begin
      r_phase[w_idx] <= w_ph + PW'(1);
      r_pend         <= w_pend_nxt;
      if (w_is_ch0) begin
        if (w_pend_eff) r_ch0_sw <= 1'b1;
        else if (w_dec) r_ch0_sw <= 1'b0;
      end
    end
  end

  // Stage 1 sample capture plus valid/channel/sync shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_re      <= '0;
      r_x_im      <= '0;
      r_vld_pipe  <= '0;
      r_sync_pipe <= '0;
      r_chn_pipe  <= '0;
    end else begin
      r_x_re        <= bus.din_dr;
      r_x_im        <= bus.din_di;
      r_vld_pipe    <= {r_vld_pipe[STAGES-1:1], w_dec};
      r_sync_pipe   <= {r_sync_pipe[STAGES-1:1], w_sync_tag};
      r_chn_pipe[1] <= bus.din_chn;
      for (int s = 2; s <= STAGES; s++) r_chn_pipe[s] <= r_chn_pipe[s-1];
    end
  end

  prach_cic_decim_ch #(
    .NUM_CHN (NUM_CHN),
    .DECIM   (DECIM)
  ) u_ch [NUM_ANT-1:0] (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_x_re   (r_x_re),
    .i_x_im   (r_x_im),
    .i_idx_s1 (r_chn_pipe[1][CW-1:0]),
    .i_idx_s2 (r_chn_pipe[2][CW-1:0]),
    .i_dec_s2 (r_vld_pipe[2]),
    .o_y_re   (w_y_re),
    .o_y_im   (w_y_im)
  );

  // Output registers: load on a decimated sample, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout_dr    <= '0;
      bus.dout_di    <= '0;
      bus.dout_chn   <= '0;
      bus.dout_valid <= 1'b0;
      bus.sync_out   <= 1'b0;
    end else begin
      bus.dout_valid <= r_vld_pipe[STAGES];
      bus.sync_out   <= r_vld_pipe[STAGES] & r_sync_pipe[STAGES];
      if (r_vld_pipe[STAGES]) begin
        bus.dout_dr  <= w_y_re;
        bus.dout_di  <= w_y_im;
        bus.dout_chn <= r_chn_pipe[STAGES];
      end
    end
  end

`ifdef PRACH_CIC_CHK_EN
  logic             r_chk_live;
  logic [CHN_W-1:0] r_prev_chn;
  logic             r_err_seq;
  logic [CHN_W-1:0] w_exp_chn;

  always_comb
    w_exp_chn = (r_prev_chn == CHN_W'(NUM_CHN - 1)) ? '0 : r_prev_chn + CHN_W'(1);

  // Sticky TDM sequence / sync placement checker; first sample is a free pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_live <= 1'b0;
      r_prev_chn <= '0;
      r_err_seq  <= 1'b0;
    end else begin
      r_chk_live <= 1'b1;
      r_prev_chn <= bus.din_chn;
      if (r_chk_live &&
          ((bus.din_chn != w_exp_chn) || (bus.sync_in && (bus.din_chn != '0))))
        r_err_seq <= 1'b1;
    end
  end

  assign err_seq = r_err_seq;
`endif

endmodule

// File: doc/prach_cic_decim.md
Name: prach_cic_decim

Overview:
- Downstream neighbour of the PRACH mixer.
- Consumes the mixer's TDM stream: 3 antennas, NUM_CHN interleaved channels, one complex sample per cycle.
- Applies a per-channel 2nd-order CIC decimate-by-DECIM filter to each antenna's I and Q.
- Emits a gated TDM stream with dout_valid for the next filter/FFT stage.

Parameters:
NUM_ANT, 3, antennas processed in parallel
NUM_CHN, 8, TDM channels; legal range 4..256 (pipeline depth < NUM_CHN removes read-modify-write hazards)
DECIM, 4, decimation ratio; power of two, 2..16

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
din_dr  in  16 x NUM_ANT  signed I input per antenna
din_di  in  16 x NUM_ANT  signed Q input per antenna
din_chn  in  8  channel index of the current input sample
sync_in  in  1  frame sync; coincides with a channel-0 sample
dout_dr  out  16 x NUM_ANT  signed decimated I
dout_di  out  16 x NUM_ANT  signed decimated Q
dout_chn  out  8  channel index of the current output
dout_valid  out  1  output sample strobe
sync_out  out  1  marks the first channel-0 output of a resynced frame

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- Input contract: a valid sample arrives every cycle; din_chn cycles 0..NUM_CHN-1 and wraps.
- Reset: all integrator, comb-delay and phase state clears to 0. The sync-pending mask is cleared. All outputs go to 0. Reset mid-stream discards everything in flight, with no partial output.
- Internal width: W = 16 + 2*log2(DECIM).
- Integrators I1 and I2 are stored per (antenna, I/Q, channel) and wrap modulo 2^W:
  - I1 += sign-extended x
  - I2 += new I1
- Per-channel phase counter, 0..DECIM-1, incremented on each arrival of that channel.
- Decimation point: at phase DECIM-1 the comb section runs on I2, with per-channel delay registers:
  - c1 = I2 - I2d
  - c2 = c1 - c1d
  - I2d and c1d are then updated.
- Scaling: S = 2*log2(DECIM). y = (c2 + 2^(S-1)) >>> S, round half up. CIC gain is exactly DECIM^2, so the result always fits in 16 bits; take the low 16 bits.
- Latency: dout_valid rises exactly 4 cycles after the clock edge that samples the phase-(DECIM-1) input. At that point:
  - dout_chn = that channel
  - all antennas are updated simultaneously
- When dout_valid is low, dout_dr, dout_di and dout_chn hold their last values.
- Sync handling:
  - sync_in sets all NUM_CHN pending bits.
  - On each channel's next arrival with its pending bit set, that sample is treated as phase 0 and the bit is cleared.
  - Filter state is not cleared by sync.
  - sync_out pulses together with dout_valid on the first channel-0 output whose window began at a sync.
- A new sync_in while bits are still pending re-sets all bits; the latest sync wins.
- In steady state, dout_valid is high for NUM_CHN consecutive cycles, then low for (DECIM-1)*NUM_CHN cycles.

Optional Feature:
- Macro: PRACH_CIC_CHK_EN.
- Defined:
  - Adds output port err_seq (1 bit).
  - err_seq is a sticky flag set when din_chn != (previous din_chn + 1) mod NUM_CHN, or when sync_in is asserted with din_chn != 0.
  - The first sample after reset is not checked. Only rst_n clears err_seq.
- Undefined: the port and all checking logic are absent; datapath behaviour is identical.

Decomposition:
- prach_pkg holds:
  - sample width 16
  - channel-index width 8
  - default NUM_ANT / NUM_CHN
  - a function returning log2 of DECIM
- Sub-module prach_cic_decim_ch: one antenna's I/Q integrator and comb state plus rounding, instantiated NUM_ANT times.
- The top level owns the phase counters, sync-pending mask, valid/chn/sync pipeline and the optional checker.

Test Plan:
- DC: all antennas, all channels, I = 1000, Q = -1000 for 10 windows -> from the 2nd window on, every output is (1000, -1000); dout_valid pattern is 8 high / 24 low.
- Impulse at phase 0: channel 3, antenna 1, I = 16384 once (zeros elsewhere) -> one output of 4096 on chn 3; subsequent outputs 0; other channels and antennas 0.
- Impulse at phase 1: same, but one arrival later -> consecutive chn 3 outputs of 3072 then 1024.
- Extremes: full-scale DC of 32767, then -32768 -> steady outputs of exactly 32767 and -32768, with no wrap.
- Resync mid-window: sync_in asserted while phases are at 2 -> sync_out pulses with the chn 0 output 4 cycles after that channel's 4th sample following the sync; window alignment restarts.
- Reset mid-stream and checker: assert rst_n low during active output -> outputs go to 0 immediately. With PRACH_CIC_CHK_EN, skipping chn 5 sets err_seq; err_seq stays set until reset.
